display_scan_mux: RTL and testbench
===================================

// Module: display_scan_mux
// PURPOSE
//   Time-multiplexed scanner that feeds the seven_seg decoder on a common-segment,
//   per-digit-enable LED display.
//   Holds a DIGITS-nibble value and steps through the digits, one digit per refresh slot.
//   Per slot it outputs the digit's 4-bit code (to seven_seg in), a one-hot digit enable and a blank flag.
//   New values are double-buffered and applied only at frame boundaries, so a frame never shows
//   a mix of old and new digits.
// PARAMETERS
//   DIGITS       4      number of digits, 1..8; digit 0 is least significant
//   REFRESH_DIV  50000  clk cycles per digit slot, >=2
//   GUARD        64     cycles at slot start with digit_en all-zero (anti-ghosting), 0..REFRESH_DIV-1
// PORTS
//   clk        in   1          system clock, rising edge
//   rst_n      in   1          asynchronous reset, active-low
//   value_in   in   4*DIGITS   new display value, nibble i -> digit i
//   load       in   1          capture value_in this cycle
//   lzb        in   1          leading-zero blanking enable
//   nibble     out  4          code of the active digit, to seven_seg in
//   digit_en   out  DIGITS     one-hot digit enable, active-high
//   blank      out  1          1 = downstream forces all segments off
//   frame_done out  1          1-cycle pulse, once per completed frame
// BEHAVIOUR
//   Reset (async, rst_n=0), held while low:
//     - pcnt=0, idx=0, disp=0, pend=0, pend_v=0.
//     - nibble=0, digit_en=0, blank=1, frame_done=0.
//   Counters:
//     - pcnt counts 0..REFRESH_DIV-1, then wraps to 0.
//     - On each pcnt wrap (terminal count, TC), idx advances 0..DIGITS-1, then wraps to 0.
//     - Frame boundary (FB) = TC while idx=DIGITS-1.
//   Load / double buffer:
//     - load=1, not FB: pend<=value_in, pend_v<=1. Back-to-back loads: last one wins.
//     - FB, load=0, pend_v=1: disp<=pend, pend_v<=0.
//     - FB, load=1: disp<=value_in (bypass), pend_v<=0. Any older pend is discarded.
//     - FB, load=0, pend_v=0: disp is unchanged.
//     - Bit widths are exact; no arithmetic on the value.
//   Outputs: all registered, so each reflects the pcnt/idx/disp state of the previous cycle.
//     - nibble   = disp[4*idx +: 4].
//     - digit_en = (pcnt < GUARD) ? 0 : onehot(idx).
//     - blank    = (pcnt < GUARD) | lzb_hit(idx).
//     - lzb_hit(i) = lzb & (i != 0) & (every nibble of disp at position >= i is 0).
//       Digit 0 is never blanked by lzb.
//     - frame_done = 1 for exactly one cycle, the cycle after each FB.
//     - disp and idx update together at FB, so the first slot of the new frame already shows
//       the new digit 0.
//   Mid-operation cases:
//     - lzb may change at any time; it takes effect on the next output register update.
//     - Reset mid-frame: every state and output returns to its reset value at once.
//       A pending load is lost.
//     - Frame period = DIGITS*REFRESH_DIV cycles. The first FB after reset release occurs
//       at cycle DIGITS*REFRESH_DIV-1.
// TESTING  (DIGITS=4, REFRESH_DIV=4, GUARD=1 unless stated)
//   1. Reset:
//      - While rst_n=0, check digit_en=0, blank=1, nibble=0, frame_done=0.
//      - After release, digit_en goes 0000,0001x3,0000,0010x3,... (repeating per digit).
//      - frame_done pulses every 16 cycles.
//   2. Load mid-frame:
//      - load=1 with value_in=16'h1234 at idx=1: the current frame keeps showing 0000.
//      - Next frame: nibble=4,3,2,1 for digit_en 0001,0010,0100,1000.
//   3. Leading-zero blanking:
//      - lzb=1, disp=16'h0070: blank=1 on digits 3 and 2; digit 1 shows nibble 7;
//        digit 0 shows nibble 0, not blanked.
//      - disp=16'h0000: only digit 0 unblanked.
//   4. FB bypass and last-wins:
//      - load 16'hAAAA mid-frame, then load 16'h5555 exactly on the FB cycle:
//        the next frame shows 5 on every digit and pend_v=0.
//      - Load 16'h1111 then 16'h2222 within one frame: the next frame shows all 2s.
//   5. Reset mid-operation:
//      - Pulse rst_n=0 for 1 cycle mid-slot with pend_v=1.
//      - Outputs return to reset values immediately (asynchronously).
//      - After release, the display shows 0000 and the pending value never appears.
//   6. GUARD=0, DIGITS=1:
//      - digit_en stays 1 permanently after reset release, blank stays 0.
//      - frame_done pulses every 4 cycles.

Source files
------------

// File: rtl/display_scan_mux.sv
// Digit scanner for a multiplexed seven-segment display: walks the digits one refresh slot
// at a time, with a guard gap per slot and a frame-aligned double buffer for new values.
module display_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  load,
  input  logic                  lzb,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  blank,
  output logic                  frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic [3:0]            nibble_q, nibble_d;
  logic [DIGITS-1:0]     digit_en_q, digit_en_d;
  logic                  blank_q, blank_d;
  logic                  frame_done_q, frame_done_d;
  logic                  tc_s, fb_s, guard_s;

  function automatic logic [3:0] sel_nibble(input logic [4*DIGITS-1:0] v,
                                            input logic [IW-1:0]       i);
    logic [3:0] sel;
    sel = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == i) begin
        sel = v[4*k +: 4];
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  // Digit i is a leading zero when it and every more significant digit are zero.
  function automatic logic lzb_hit(input logic                  en,
                                   input logic [4*DIGITS-1:0]   v,
                                   input logic [IW-1:0]         i);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if ((IW'(k) >= i) && (v[4*k +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end else begin
        upper_zero = upper_zero;
      end
    end
    return en & (i != IW'(0)) & upper_zero;
  endfunction

  function automatic logic [DIGITS-1:0] onehot(input logic [IW-1:0] i);
    logic [DIGITS-1:0] oh;
    for (int k = 0; k < DIGITS; k++) begin
      oh[k] = (IW'(k) == i);
    end
    return oh;
  endfunction

  generate
    if (GUARD == 0) begin : g_no_guard
      assign guard_s = 1'b0;
    end else begin : g_guard
      assign guard_s = (pcnt_q < PW'(GUARD));
    end
  endgenerate

  // Slot/digit counters and the frame-aligned double buffer.
  always_comb begin
    tc_s     = (pcnt_q == PCNT_LAST);
    fb_s     = tc_s && (idx_q == IDX_LAST);
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;

    if (tc_s) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PW'(1);
    end

    if (!tc_s) begin
      idx_d = idx_q;
    end else if (idx_q == IDX_LAST) begin
      idx_d = '0;
    end else begin
      idx_d = idx_q + IW'(1);
    end

    // A load on the boundary itself bypasses the buffer and discards any older pending value.
    if (fb_s) begin
      pend_v_d = 1'b0;
      if (load) begin
        disp_d = value_in;
      end else if (pend_v_q) begin
        disp_d = pend_q;
      end else begin
        disp_d = disp_q;
      end
    end else if (load) begin
      pend_d   = value_in;
      pend_v_d = 1'b1;
    end else begin
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
    end
  end

  // Output next-state, derived from the current counter and display state.
  always_comb begin
    nibble_d     = sel_nibble(disp_q, idx_q);
    frame_done_d = fb_s;
    blank_d      = guard_s | lzb_hit(lzb, disp_q, idx_q);
    if (guard_s) begin
      digit_en_d = '0;
    end else begin
      digit_en_d = onehot(idx_q);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      nibble_q     <= 4'h0;
      digit_en_q   <= '0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      nibble_q     <= nibble_d;
      digit_en_q   <= digit_en_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign nibble     = nibble_q;
  assign digit_en   = digit_en_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: a 4-digit instance under directed plus random stimulus and a
// 1-digit no-guard instance under random stimulus, both against a cycle-count based model.
module tb_display_scan_mux;

  typedef struct packed {
    logic [3:0] nib;
    logic [7:0] en;
    logic       blank;
    logic       fd;
  } exp_t;

  localparam exp_t RST_EXP = '{nib: 4'h0, en: 8'h00, blank: 1'b1, fd: 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value1;
  logic        load1, lzb1;
  logic [3:0]  nib1;
  logic [3:0]  en1;
  logic        blank1, fd1;
  logic [3:0]  value2;
  logic        load2, lzb2;
  logic [3:0]  nib2;
  logic [0:0]  en2;
  logic        blank2, fd2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  display_scan_mux #(.DIGITS(4), .REFRESH_DIV(4), .GUARD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .value_in(value1), .load(load1), .lzb(lzb1),
    .nibble(nib1), .digit_en(en1), .blank(blank1), .frame_done(fd1));

  display_scan_mux #(.DIGITS(1), .REFRESH_DIV(4), .GUARD(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .value_in(value2), .load(load2), .lzb(lzb2),
    .nibble(nib2), .digit_en(en2), .blank(blank2), .frame_done(fd2));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic fb_of(input int t, input int d, input int r);
    return (t % (d * r)) == (d * r - 1);
  endfunction

  // Expected registered outputs for the state reached after t clocks since reset release.
  function automatic exp_t expect_out(input int t, input logic [31:0] disp, input logic lzb,
                                      input int d, input int r, input int g);
    exp_t        e;
    int          pc;
    int          ix;
    logic [31:0] upper;
    pc      = t % r;
    ix      = (t / r) % d;
    upper   = disp >> (4 * ix);
    e.nib   = upper[3:0];
    e.en    = (pc < g) ? 8'h00 : (8'h01 << ix);
    e.blank = (pc < g) || (lzb && (ix != 0) && (upper == 32'h0));
    e.fd    = fb_of(t, d, r);
    return e;
  endfunction

  int          t1, t2;
  logic [15:0] disp1, pend1;
  logic [3:0]  disp2, pend2;
  logic        pv1, pv2;
  exp_t        e1, e2;

  // Model of the 4-digit instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1 <= 0; disp1 <= 16'h0; pend1 <= 16'h0; pv1 <= 1'b0; e1 <= RST_EXP;
    end else begin
      e1 <= expect_out(t1, 32'(disp1), lzb1, 4, 4, 1);
      if (fb_of(t1, 4, 4)) begin
        pv1 <= 1'b0;
        if (load1) disp1 <= value1;
        else if (pv1) disp1 <= pend1;
      end else if (load1) begin
        pend1 <= value1;
        pv1   <= 1'b1;
      end
      t1 <= t1 + 1;
    end
  end

  // Model of the 1-digit instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t2 <= 0; disp2 <= 4'h0; pend2 <= 4'h0; pv2 <= 1'b0; e2 <= RST_EXP;
    end else begin
      e2 <= expect_out(t2, 32'(disp2), lzb2, 1, 4, 0);
      if (fb_of(t2, 1, 4)) begin
        pv2 <= 1'b0;
        if (load2) disp2 <= value2;
        else if (pv2) disp2 <= pend2;
      end else if (load2) begin
        pend2 <= value2;
        pv2   <= 1'b1;
      end
      t2 <= t2 + 1;
    end
  end

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    check_eq("nibble1",   32'(nib1),   32'(e1.nib));
    check_eq("digit_en1", 32'(en1),    32'(e1.en));
    check_eq("blank1",    32'(blank1), 32'(e1.blank));
    check_eq("fdone1",    32'(fd1),    32'(e1.fd));
    check_eq("nibble2",   32'(nib2),   32'(e2.nib));
    check_eq("digit_en2", 32'(en2),    32'(e2.en));
    check_eq("blank2",    32'(blank2), 32'(e2.blank));
    check_eq("fdone2",    32'(fd2),    32'(e2.fd));
  end

  task automatic step();
    @(negedge clk);
    #1;
    load1  = 1'b0;
    load2  = ($urandom_range(3) == 0);
    value2 = 4'($urandom);
    if ($urandom_range(15) == 0) lzb2 = ~lzb2;
  endtask

  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    while (((t1 % 16) != pos) && (n < 64)) begin
      step();
      n++;
    end
    if (n == 64) check_eq("wait_pos_timeout", 32'(t1 % 16), 32'(pos));
  endtask

  task automatic load_val(input logic [15:0] v);
    load1  = 1'b1;
    value1 = v;
    step();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check_eq("async_nibble1", 32'(nib1),   32'h0);
    check_eq("async_en1",     32'(en1),    32'h0);
    check_eq("async_blank1",  32'(blank1), 32'h1);
    check_eq("async_fdone1",  32'(fd1),    32'h0);
    check_eq("async_en2",     32'(en2),    32'h0);
    check_eq("async_blank2",  32'(blank2), 32'h1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    load1 = 1'b0; value1 = 16'h0; lzb1 = 1'b0;
    load2 = 1'b0; value2 = 4'h0;  lzb2 = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (40) step();

    wait_pos(4);  load_val(16'h1234); repeat (40) step();

    lzb1 = 1'b1;
    wait_pos(9);  load_val(16'h0070); repeat (40) step();
    wait_pos(3);  load_val(16'h0000); repeat (40) step();
    lzb1 = 1'b0;

    wait_pos(5);  load_val(16'hAAAA);
    wait_pos(15); load_val(16'h5555); repeat (40) step();
    wait_pos(2);  load_val(16'h1111);
    wait_pos(7);  load_val(16'h2222); repeat (40) step();

    wait_pos(5);  load_val(16'hBEEF);
    reset_pulse();
    repeat (40) step();

    for (int i = 0; i < 800; i++) begin
      step();
      load1  = ($urandom_range(7) == 0);
      value1 = 16'($urandom);
      if ($urandom_range(15) == 0) lzb1 = ~lzb1;
      if ($urandom_range(249) == 0) reset_pulse();
    end
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
